// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store unit: operation codes, FSM states,
// access-size decode and lane-count helpers.
package ls_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } ls_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_MERGE,
        ST_WR,
        ST_RESP
    } ls_state_t;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } ls_size_t;

    localparam int LANES = 4;
    localparam int OFF_W = 2;

    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_w_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic ls_size_t op_size(input ls_op_t op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_store(input ls_op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/ls_lane_extract.sv
// Combinational lane selector: picks the byte/half addressed by offset and extends it,
// and reports the bit mask of that lane so stores can merge into the same position.
module ls_lane_extract
    import ls_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W_P = off_w_of(DATA_W)
) (
    input  logic [DATA_W-1:0]  word,
    input  logic [OFF_W_P-1:0] offset,
    input  ls_op_t             op,
    output logic [DATA_W-1:0]  result,
    output logic [DATA_W-1:0]  lane_mask
);

    int unsigned byte_sh;
    int unsigned half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Half accesses drop offset bit 0, so a misaligned half reads its enclosing half.
    always_comb begin
        byte_sh   = 8 * int'(offset);
        half_sh   = 16 * int'(offset >> 1);
        byte_v    = 8'(word >> byte_sh);
        half_v    = 16'(word >> half_sh);
        result    = word;
        lane_mask = '1;
        case (op)
            OP_LH:   result = {{(DATA_W-16){half_v[15]}}, half_v};
            OP_LHU:  result = {{(DATA_W-16){1'b0}}, half_v};
            OP_LB:   result = {{(DATA_W-8){byte_v[7]}}, byte_v};
            OP_LBU:  result = {{(DATA_W-8){1'b0}}, byte_v};
            default: result = word;
        endcase
        case (op_size(op))
            SZ_HALF: lane_mask = DATA_W'(16'hFFFF) << half_sh;
            SZ_BYTE: lane_mask = DATA_W'(8'hFF) << byte_sh;
            default: lane_mask = '1;
        endcase
    end

endmodule

// File: rtl/ls_unit.sv
// Multicycle load/store unit with read-modify-write for sub-word stores.
// Define LS_MISALIGN_EXC_EN to trap misaligned word/half accesses instead of truncating them.
module ls_unit
    import ls_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              exc_misaligned
);

    localparam int LANES_L = lanes_of(DATA_W);
    localparam int OFF_L   = off_w_of(DATA_W);
    localparam int CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    ls_state_t         state_q, state_d;
    ls_op_t            op_q, op_d, req_op_t;
    logic [OFF_L-1:0]  off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              exc_q, exc_d;
    logic              misaligned;
    logic [DATA_W-1:0] ext_result;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] repl_data;

    assign req_op_t = ls_op_t'(req_op);

    ls_lane_extract #(
        .DATA_W  (DATA_W),
        .OFF_W_P (OFF_L)
    ) u_extract (
        .word      (mem_rdata),
        .offset    (off_q),
        .op        (op_q),
        .result    (ext_result),
        .lane_mask (lane_mask)
    );

    always_comb begin
`ifdef LS_MISALIGN_EXC_EN
        misaligned = ((op_size(req_op_t) == SZ_WORD) && (req_addr[OFF_L-1:0] != '0)) ||
                     ((op_size(req_op_t) == SZ_HALF) && req_addr[0]);
`else
        misaligned = 1'b0;
`endif
        repl_data = (op_q == OP_SH) ? {(LANES_L/2){wdata_q[15:0]}} : {LANES_L{wdata_q[7:0]}};
    end

    // Strobes and ready are registered decodes of the next state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = '0;
        exc_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_op_t;
                    off_d      = req_addr[OFF_L-1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = {req_addr[ADDR_W-1:OFF_L], {OFF_L{1'b0}}};
                    if (misaligned) begin
                        state_d = ST_RESP;
                        exc_d   = 1'b1;
                    end else if (req_op_t == OP_SW) begin
                        state_d     = ST_WR;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    word_d = mem_rdata;
                    if (is_store(op_q)) begin
                        state_d = ST_MERGE;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_data_d = ext_result;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MERGE: begin
                mem_wdata_d = (word_q & ~lane_mask) | (repl_data & lane_mask);
                state_d     = ST_WR;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        mem_rd_d    = (state_d == ST_RD);
        mem_wr_d    = (state_d == ST_WR);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            off_q       <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rsp_valid_q <= rsp_valid_d;
            exc_q       <= exc_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign mem_addr       = mem_addr_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wr         = mem_wr_q;
    assign mem_wdata      = mem_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign exc_misaligned = exc_q;

endmodule

// File: tb/tb_ls_unit.sv
// Self-checking bench for ls_unit: fixed-latency memory model plus a byte-array reference
// model of load extension and sub-word store merging, directed cases then random traffic.
module tb_ls_unit;
    import ls_pkg::*;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_LAT   = 2;
    localparam int MEM_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              exc_misaligned;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    ls_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .exc_misaligned (exc_misaligned)
    );

    // Memory model: data appears MEM_LAT cycles after the read strobe, garbage otherwise.
    logic [31:0]        mem     [MEM_WORDS];
    logic [31:0]        ref_mem [MEM_WORDS];
    logic [MEM_LAT-1:0] rd_pipe_v = '0;
    logic [5:0]         rd_pipe_idx [MEM_LAT];
    logic [31:0]        garbage = 32'h0;
    int                 rd_cnt = 0;
    int                 wr_cnt = 0;
    logic [31:0]        last_rd_addr = 32'h0;
    logic [31:0]        last_wr_addr = 32'h0;
    logic [31:0]        last_wr_data = 32'h0;

    assign mem_rdata = rd_pipe_v[MEM_LAT-1] ? mem[rd_pipe_idx[MEM_LAT-1]] : garbage;

    always @(posedge clk) begin
        garbage <= $urandom;
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            rd_pipe_v[i]   <= rd_pipe_v[i-1];
            rd_pipe_idx[i] <= rd_pipe_idx[i-1];
        end
        rd_pipe_v[0]   <= (mem_rd === 1'b1);
        rd_pipe_idx[0] <= mem_addr[7:2];
        if (mem_rd === 1'b1) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
        end
        if (mem_wr === 1'b1) begin
            wr_cnt               <= wr_cnt + 1;
            last_wr_addr         <= mem_addr;
            last_wr_data         <= mem_wdata;
            mem[mem_addr[7:2]]   <= mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_exc"}, 32'(exc_misaligned), 32'd0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_rsp_data"}, rsp_data, 32'd0);
    endtask

    // Issue one request, let it complete while toggling junk on the request port, and check it.
    task automatic applyStimulus(input ls_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
        int          idx, off, hb, n, guard, busy_ready, rd0, wr0;
        int          exp_lat, exp_rd, exp_wr;
        logic [7:0]  b [4];
        logic [15:0] half;
        logic [31:0] exp_data, new_word;
        logic        mis, got;
        string       tag;

        tag  = op.name();
        idx  = int'(addr[7:2]);
        off  = int'(addr[1:0]);
        hb   = off / 2;
        for (int i = 0; i < 4; i++) b[i] = 8'(ref_mem[idx] >> (8 * i));
        half = {b[2*hb+1], b[2*hb]};
        mis  = 1'b0;
`ifdef LS_MISALIGN_EXC_EN
        mis = ((op == OP_LW || op == OP_SW) && off != 0) ||
              ((op == OP_LH || op == OP_LHU || op == OP_SH) && (off % 2) != 0);
`endif
        exp_data = 32'h0;
        new_word = ref_mem[idx];
        case (op)
            OP_LW:  exp_data = ref_mem[idx];
            OP_LH:  exp_data = half[15] ? (32'hFFFF0000 | 32'(half)) : 32'(half);
            OP_LHU: exp_data = 32'(half);
            OP_LB:  exp_data = b[off][7] ? (32'hFFFFFF00 | 32'(b[off])) : 32'(b[off]);
            OP_LBU: exp_data = 32'(b[off]);
            OP_SW:  new_word = wdata;
            OP_SH: begin
                b[2*hb]   = wdata[7:0];
                b[2*hb+1] = wdata[15:8];
                new_word  = {b[3], b[2], b[1], b[0]};
            end
            default: begin
                b[off]   = wdata[7:0];
                new_word = {b[3], b[2], b[1], b[0]};
            end
        endcase
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0; exp_data = 32'h0;
        end else if (op == OP_SW) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
        end else if (is_store(op)) begin
            exp_lat = 4 + MEM_LAT; exp_rd = 1; exp_wr = 1;
        end else begin
            exp_lat = 2 + MEM_LAT; exp_rd = 1; exp_wr = 0;
        end

        @(negedge clk);
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 3'(op);
        req_addr  = addr;
        req_wdata = wdata;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        n = 0; got = 1'b0; busy_ready = 0;
        while (n < 30 && !got) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) begin
                got       = 1'b1;
                req_valid = 1'b0;
            end else begin
                if (req_ready !== 1'b0) busy_ready++;
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 3'($urandom_range(0, 7));
                req_addr  = 32'($urandom_range(0, 255));
                req_wdata = $urandom;
            end
        end
        if (!got) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'(exp_lat));
        checkOutput({tag, "_rsp_data"}, rsp_data, exp_data);
        checkOutput({tag, "_exc"}, 32'(exc_misaligned), 32'(mis));
        checkOutput({tag, "_busy_ready"}, 32'(busy_ready), 32'd0);
        checkOutput({tag, "_rd_count"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        checkOutput({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_rd == 1) checkOutput({tag, "_rd_addr"}, last_rd_addr, {addr[31:2], 2'b00});
        if (exp_wr == 1) begin
            checkOutput({tag, "_wr_addr"}, last_wr_addr, {addr[31:2], 2'b00});
            checkOutput({tag, "_wr_data"}, last_wr_data, new_word);
            ref_mem[idx] = new_word;
        end
    endtask

    initial begin
        int wr_before;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;

        applyStimulus(OP_LB,  32'h13, 32'h0);
        applyStimulus(OP_LBU, 32'h13, 32'h0);
        applyStimulus(OP_LH,  32'h12, 32'h0);
        applyStimulus(OP_LHU, 32'h10, 32'h0);
        applyStimulus(OP_SB,  32'h11, 32'h000000CC);
        applyStimulus(OP_LW,  32'h10, 32'h0);
        checkOutput("mem_after_sb", mem[4], 32'h8899CCBB);
        applyStimulus(OP_SW,  32'h20, 32'hDEADBEEF);
        applyStimulus(OP_LW,  32'h12, 32'h0);
        applyStimulus(OP_SH,  32'h16, 32'h1234ABCD);

        for (int i = 0; i < 150; i++) begin
            applyStimulus(ls_op_t'(3'($urandom_range(0, 7))),
                          32'($urandom_range(0, 255)), $urandom);
        end

        // Reset during the read-wait phase of a half store must abort without writing.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'(OP_SH);
        req_addr  = 32'h14;
        req_wdata = 32'h00005A5A;
        wr_before = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("midreset");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midreset_no_write", 32'(wr_cnt - wr_before), 32'd0);
        checkOutput("midreset_mem", mem[5], ref_mem[5]);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
